// File: rtl/divider_pkg.sv
// Shared arithmetic definitions for the iterative divider: default width,
// FSM state encoding and the divide-by-zero quotient fill value.
package divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } div_state_t;

    // Replicated across the full width: divide-by-zero quotient is all ones.
    localparam logic DZ_FILL = 1'b1;

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division step: shift in the next dividend
// bit, then subtract or add the divisor depending on the current sign.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   prem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH:0]   prem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {prem[WIDTH-1:0], dvd_msb};
        if (prem[WIDTH] == 1'b0)
            prem_next = shifted - {1'b0, dvs};
        else
            prem_next = shifted + {1'b0, dvs};
        q_bit = ~prem_next[WIDTH];
    end

endmodule

// File: rtl/divider.sv
// Iterative non-restoring integer divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement signed division (truncating).
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             val,
    output logic             busy,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    div_state_t       state;
    logic [WIDTH-1:0] dvd, dvs;
    logic [WIDTH-1:0] acc, dvr;
    logic [WIDTH:0]   prem, prem_nxt;
    logic             q_bit;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] mag_dvd, mag_dvs;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic             is_ovf;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic neg_q, neg_r, ovf_q;
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem),
        .dvd_msb   (acc[WIDTH-1]),
        .dvs       (dvr),
        .prem_next (prem_nxt),
        .q_bit     (q_bit)
    );

    always_comb begin
        mag_dvd = dvd;
        mag_dvs = dvs;
        is_ovf  = 1'b0;
        q_fin   = acc;
        // Final restore only needs the low bits; the corrected remainder is < divisor.
        r_fin   = prem[WIDTH] ? (prem[WIDTH-1:0] + dvr) : prem[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
        if (dvd[WIDTH-1]) mag_dvd = -dvd;
        if (dvs[WIDTH-1]) mag_dvs = -dvs;
        is_ovf = (dvd == INT_MIN) && (dvs == {WIDTH{1'b1}});
        if (neg_q) q_fin = -acc;
        if (neg_r) r_fin = -r_fin;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dvd         <= '0;
            dvs         <= '0;
            acc         <= '0;
            dvr         <= '0;
            prem        <= '0;
            cnt         <= '0;
            quot        <= '0;
            rem         <= '0;
            val         <= 1'b0;
            busy        <= 1'b0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            val <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (en) begin
                        dvd         <= op1;
                        dvs         <= op2;
                        div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
                        ovf_q       <= 1'b0;
`endif
                        busy        <= 1'b1;
                        state       <= S_PREP;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_PREP: begin
                    if (dvs == '0) begin
                        quot        <= {WIDTH{DZ_FILL}};
                        rem         <= dvd;
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        val         <= 1'b1;
                        state       <= S_DONE;
                    end else if (is_ovf) begin
                        // dvd is INT_MIN here, which is also the saturated quotient.
                        quot  <= dvd;
                        rem   <= '0;
`ifdef DIV_SIGNED_EN
                        ovf_q <= 1'b1;
`endif
                        busy  <= 1'b0;
                        val   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        acc   <= mag_dvd;
                        dvr   <= mag_dvs;
                        prem  <= '0;
                        cnt   <= CW'(WIDTH - 1);
`ifdef DIV_SIGNED_EN
                        neg_q <= dvd[WIDTH-1] ^ dvs[WIDTH-1];
                        neg_r <= dvd[WIDTH-1];
`endif
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    prem <= prem_nxt;
                    acc  <= {acc[WIDTH-2:0], q_bit};
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    quot  <= q_fin;
                    rem   <= r_fin;
                    busy  <= 1'b0;
                    val   <= 1'b1;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
